// File: rtl/data_dist.sv
`default_nettype none
// ============================================================================
// Module   : data_dist
// Purpose  : 1-to-4 demultiplexer, one registered single-entry buffer and one
//            saturating accepted-word counter per channel. Defining the macro
//            DATA_DIST_BCAST_EN adds the bcast input (load all four channels).
// Revision : 1.0 - initial release
// ============================================================================
module data_dist #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_sel,
    input  logic [WIDTH-1:0]   in_data,
`ifdef DATA_DIST_BCAST_EN
    input  logic               bcast,
`endif
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [4*CNT_W-1:0] out_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic       w_bcast;
    logic [3:0] w_free;
    logic       w_xfer;

`ifdef DATA_DIST_BCAST_EN
    assign w_bcast = bcast;
`else
    assign w_bcast = 1'b0;
`endif

    // Readiness never looks at in_valid, so upstream may wait on it safely.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (w_bcast) begin
                in_ready = &w_free;
            end else begin
                in_ready = w_free[in_sel];
            end
        end
    end

    assign w_xfer = in_valid && in_ready;

    for (genvar k = 0; k < 4; k++) begin : g_chan
        localparam logic [1:0] c_idx = 2'(k);

        logic             w_load;
        logic             valid_d;
        logic             valid_q;
        logic [WIDTH-1:0] data_d;
        logic [WIDTH-1:0] data_q;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W-1:0] cnt_q;

        assign w_free[k] = !valid_q || out_ready[k];

        // A load in the same cycle as a drain refills the slot without a bubble.
        always_comb begin
            w_load  = w_xfer && (w_bcast || (in_sel == c_idx));
            valid_d = w_load || (valid_q && !out_ready[k]);
            data_d  = data_q;
            cnt_d   = cnt_q;
            if (w_load) begin
                data_d = in_data;
                if (cnt_q != c_cnt_max) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                cnt_q   <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                cnt_q   <= cnt_d;
            end
        end

        assign out_valid[k]               = valid_q;
        assign out_data[k*WIDTH +: WIDTH] = data_q;
        assign out_cnt[k*CNT_W +: CNT_W]  = cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_data_dist.sv
`default_nettype none
// Randomized and directed stimulus for data_dist, checked by a queue-based
// scoreboard: the driver predicts acceptance and enqueues words, the monitor pops on drains.
module tb_data_dist;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_sel;
    logic [WIDTH-1:0]   in_data;
    logic               bcast;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [4*CNT_W-1:0] out_cnt;

    data_dist #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
`ifdef DATA_DIST_BCAST_EN
        .bcast     (bcast),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: each channel is a queue of words awaiting consumption.
    logic [WIDTH-1:0] exp_q [4][$];
    int               exp_cnt [4];
    int               n_cmp  = 0;
    int               n_fail = 0;
    bit               checking = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares visible state, then retires any word drained this cycle.
    always @(negedge clk) begin
        if (checking) begin
            logic [3:0] ev;
            for (int k = 0; k < 4; k++) ev[k] = (exp_q[k].size() != 0);
            check("out_valid", {60'd0, out_valid}, {60'd0, ev});
            for (int k = 0; k < 4; k++) begin
                check($sformatf("out_cnt[%0d]", k),
                      {56'd0, out_cnt[k*CNT_W +: CNT_W]}, 64'(exp_cnt[k]));
                if (exp_q[k].size() != 0) begin
                    check($sformatf("out_data[%0d]", k),
                          {56'd0, out_data[k*WIDTH +: WIDTH]}, {56'd0, exp_q[k][0]});
                    if (out_ready[k]) void'(exp_q[k].pop_front());
                end
            end
        end
    end

    // One clock of stimulus; after the monitor has retired drains, an empty queue
    // means the channel can take a word in this same cycle.
    task automatic step(input logic r, input logic v, input logic [1:0] s,
                        input logic [WIDTH-1:0] d, input logic [3:0] ordy, input logic b);
        logic exp_rdy;
        @(posedge clk);
        #1;
        rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy; bcast = b;
        @(negedge clk);
        #1;
        if (r) begin
            exp_rdy = 1'b0;
        end else if (b) begin
            exp_rdy = 1'b1;
            for (int k = 0; k < 4; k++) if (exp_q[k].size() != 0) exp_rdy = 1'b0;
        end else begin
            exp_rdy = (exp_q[s].size() == 0);
        end
        if (checking) check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                exp_q[k].delete();
                exp_cnt[k] = 0;
            end
        end else if (v && exp_rdy) begin
            for (int k = 0; k < 4; k++) begin
                if (b || (int'(s) == k)) begin
                    exp_q[k].push_back(d);
                    exp_cnt[k] = (exp_cnt[k] >= CMAX) ? CMAX : exp_cnt[k] + 1;
                end
            end
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 2'd0, '0, 4'h0, 1'b0);
        checking = 1'b1;
        step(1'b1, 1'b1, 2'd1, 8'hEE, 4'hF, 1'b0);
    endtask

    initial begin
        logic rb;
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0;
        out_ready = 4'h0; bcast = 1'b0;
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;

        do_reset();
        check("reset out_data", {32'd0, out_data}, 64'd0);

        // Single load to channel 2, then in_ready probes for sel 2 and sel 0
        step(1'b0, 1'b1, 2'd2, 8'hA5, 4'h0, 1'b0);
        step(1'b0, 1'b0, 2'd2, 8'h00, 4'h0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0);

        // Load into a full channel that drains in the same cycle
        do_reset();
        step(1'b0, 1'b1, 2'd1, 8'h11, 4'h0, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'h3C, 4'b0010, 1'b0);
        step(1'b0, 1'b0, 2'd1, 8'h00, 4'h0, 1'b0);

        // Fill every channel, then a fifth word must stall
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 2'(k), 8'(k + 1), 4'h0, 1'b0);
        step(1'b0, 1'b1, 2'd0, 8'h05, 4'h0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
        check("ch0 held", {56'd0, out_data[7:0]}, 64'h01);

        // Counter saturation on channel 3
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 2'd3, 8'(i), 4'b1000, 1'b0);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
        check("cnt3 saturated", {56'd0, out_cnt[31:24]}, 64'd255);

        // Reset overrides a pending transfer while channels 0 and 2 are full
        do_reset();
        step(1'b0, 1'b1, 2'd0, 8'h10, 4'h0, 1'b0);
        step(1'b0, 1'b1, 2'd2, 8'h20, 4'h0, 1'b0);
        step(1'b1, 1'b1, 2'd1, 8'h30, 4'hF, 1'b0);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
        check("post-reset out_data", {32'd0, out_data}, 64'd0);

`ifdef DATA_DIST_BCAST_EN
        do_reset();
        step(1'b0, 1'b1, 2'd2, 8'h77, 4'h0, 1'b1);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'b1110, 1'b0);
        step(1'b0, 1'b1, 2'd3, 8'h99, 4'b1110, 1'b1);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
`endif

        // Randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rb = 1'b0;
`ifdef DATA_DIST_BCAST_EN
            rb = ($urandom_range(0, 7) == 0);
`endif
            step(($urandom_range(0, 127) == 0), 1'($urandom), 2'($urandom),
                 8'($urandom), 4'($urandom), rb);
        end
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
        step(1'b0, 1'b0, 2'd0, 8'h00, 4'hF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
